hpi_bus_arbiter: RTL

Two-requester arbiter and bus-cycle sequencer for the CY7C67300 HPI port. It sits between the HPI pins (nCS, nRD, nWR, A[1:0], D[15:0]) and two internal masters: the mailbox/command engine and the block-data mover. It grants the single HPI bus round-robin and generates each read or write cycle with parameterised setup, strobe, hold and turnaround phases, counted in `clk` cycles.

---
 rtl/hpi_pkg.sv | 28 ++
 rtl/hpi_bus_arbiter_if.sv | 29 ++
 rtl/hpi_rr_arbiter.sv | 27 ++
 rtl/hpi_bus_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared constants for the HPI bus arbiter slice: FSM encoding, HPI register
// selects and default cycle timing.
package hpi_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

    typedef logic [1:0] hpi_addr_t;

    localparam hpi_addr_t HPI_DATA    = 2'd0;
    localparam hpi_addr_t HPI_MAILBOX = 2'd1;
    localparam hpi_addr_t HPI_ADDR    = 2'd2;
    localparam hpi_addr_t HPI_STATUS  = 2'd3;

    localparam int unsigned DEF_SETUP_CYCLES  = 1;
    localparam int unsigned DEF_STROBE_CYCLES = 2;
    localparam int unsigned DEF_HOLD_CYCLES   = 1;
    localparam int unsigned DEF_TURN_CYCLES   = 1;

    // Phase counter counts down to zero, so a phase of n cycles loads n-1.
    function automatic logic [3:0] phase_load(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/hpi_bus_arbiter_if.sv
// Requester-side bundle of the HPI arbiter: two request channels plus the
// shared read data and busy flag.
interface hpi_bus_arbiter_if;
    import hpi_pkg::*;

    logic      req0;
    logic      req1;
    logic      we0;
    logic      we1;
    hpi_addr_t addr0;
    hpi_addr_t addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic      ack0;
    logic      ack1;
    logic [15:0] rdata;
    logic      busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, busy
    );

endinterface

// File: rtl/hpi_rr_arbiter.sv
// Two-way round-robin grant for the HPI bus; last_grant resets to 1 so
// requester 0 wins the first tie.
module hpi_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_sel
);

    logic last_grant;

    always_comb begin
        grant_valid = req0 | req1;
        grant_sel   = req1 & (~req0 | ~last_grant);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant_en && grant_valid)
            last_grant <= grant_sel;
    end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// Arbitrates two internal masters onto the CY7C67300 HPI pins and sequences
// each read/write cycle through setup, strobe, hold and turnaround phases.
module hpi_bus_arbiter
    import hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned TURN_CYCLES   = DEF_TURN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    hpi_bus_arbiter_if.slave bus,
    output logic             hpi_csn,
    output logic             hpi_oen,
    output logic             hpi_wen,
    output hpi_addr_t        hpi_address,
    inout  wire logic [15:0] hpi_data
);

    logic [2:0]  state;
    logic [3:0]  phase_cnt;
    logic        phase_done;
    logic        cur_we;
    logic        cur_sel;
    logic [15:0] cur_wdata;
    logic        data_oe;
    logic [15:0] rdata_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        busy_q;

    logic        arb_en;
    logic        grant_valid;
    logic        grant_sel;
    logic        sel_we;
    hpi_addr_t   sel_addr;
    logic [15:0] sel_wdata;

    hpi_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .req0        (bus.req0),
        .req1        (bus.req1),
        .grant_en    (arb_en),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        arb_en     = (state == ST_IDLE);
        phase_done = (phase_cnt == '0);
        sel_we     = grant_sel ? bus.we1    : bus.we0;
        sel_addr   = grant_sel ? bus.addr1  : bus.addr0;
        sel_wdata  = grant_sel ? bus.wdata1 : bus.wdata0;
    end

    assign hpi_data  = data_oe ? cur_wdata : 'z;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

    // Pin levels are set on entry to each phase so every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            cur_we      <= 1'b0;
            cur_sel     <= 1'b0;
            cur_wdata   <= '0;
            data_oe     <= 1'b0;
            hpi_csn     <= 1'b1;
            hpi_oen     <= 1'b1;
            hpi_wen     <= 1'b1;
            hpi_address <= '0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        cur_sel     <= grant_sel;
                        cur_we      <= sel_we;
                        cur_wdata   <= sel_wdata;
                        hpi_address <= sel_addr;
                        hpi_csn     <= 1'b0;
                        data_oe     <= sel_we;
                        busy_q      <= 1'b1;
                        phase_cnt   <= phase_load(SETUP_CYCLES);
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        hpi_oen   <= cur_we;
                        hpi_wen   <= ~cur_we;
                        phase_cnt <= phase_load(STROBE_CYCLES);
                        state     <= ST_STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (phase_done) begin
                        hpi_oen   <= 1'b1;
                        hpi_wen   <= 1'b1;
                        if (!cur_we)
                            rdata_q <= hpi_data;
                        phase_cnt <= phase_load(HOLD_CYCLES);
                        state     <= ST_HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
                        hpi_csn   <= 1'b1;
                        data_oe   <= 1'b0;
                        ack0_q    <= ~cur_sel;
                        ack1_q    <= cur_sel;
                        phase_cnt <= phase_load(TURN_CYCLES);
                        state     <= ST_TURN;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    if (phase_done) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
